float_add_scheduler: RTL and testbench
======================================

# float_add_scheduler

Shares one multi-cycle single-precision float adder among `N_REQ` requesters. Requests are granted round-robin. For each operation the block issues a start pulse to the adder, waits for its done strobe or a timeout, and returns the sum and the 2-bit status flag to the granted requester over a valid/ready handshake. It sits between client blocks and the single float-adder instance.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT`, default 64: maximum cycles allowed between `fa_start` and `fa_done`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `req_valid`  in  N_REQ: per-requester request valid.
- `req_ready`  out  N_REQ: one-hot accept, asserted only to the granted requester.
- `req_x`  in  32*N_REQ: packed x operands; requester i uses bits [32i+31:32i].
- `req_y`  in  32*N_REQ: packed y operands, same packing as `req_x`.
- `resp_valid`  out  N_REQ: one-hot result valid.
- `resp_ready`  in  N_REQ: per-requester result accept.
- `resp_z`  out  32: result value.
- `resp_flag`  out  2: status code; 00 ok, 01 overflow, 10 underflow, 11 abnormal or timeout.
- `fa_start`  out  1: one-cycle start pulse to the adder.
- `fa_x`, `fa_y`  out  32 each: adder operands, held from start until done.
- `fa_done`  in  1: adder completion strobe.
- `fa_z`  in  32: adder result.
- `fa_flag`  in  2: adder status.
- `fa_kill`  out  1: one-cycle pulse that forces the adder back to its initial state.
- `busy`  out  1: high in every state except IDLE.

## Operation
The FSM has four states: IDLE, ISSUE, WAIT and RESP.

- **IDLE**
  - Grant `g` is the first i with `req_valid[i]` set, searching from `rr_ptr` upward and wrapping modulo N_REQ.
  - `req_ready[g]=1` is asserted combinationally.
  - On the handshake: latch `g`, load `fa_x`/`fa_y` from slice g, go to ISSUE.
  - With no valid request, stay in IDLE.
- **ISSUE**
  - `fa_start=1` for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - If `fa_done=1`: capture `fa_z`/`fa_flag` into `resp_z`/`resp_flag`, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT-1: `resp_z=32'hFFFF_FFFF`, `resp_flag=2'b11`, `fa_kill=1` for one cycle, go to RESP.
- **RESP**
  - `resp_valid[g]=1` is held, with z and flag stable, until `resp_ready[g]=1`.
  - On the handshake: `rr_ptr<=(g+1) mod N_REQ`, go to IDLE.

Protocol rules:
- A requester must keep `req_valid` and its operands stable until `req_ready`. Dropping `req_valid` before grant simply withdraws the request.
- `fa_done` outside WAIT is ignored.
- `fa_x`/`fa_y` are unchanged from ISSUE until the next IDLE handshake.

## Timing
- Reset values:
  - State IDLE, `rr_ptr=0`.
  - `req_ready`, `resp_valid`, `fa_start`, `fa_kill`, `busy` all 0.
  - `fa_x`, `fa_y`, `resp_z`, `resp_flag` all 0.
- Latency, with the request handshake at cycle 0:
  - `fa_start` at cycle 1.
  - If `fa_done` arrives at cycle 1+L (L≥1), `resp_valid` is asserted at cycle 2+L.
  - Minimum issue interval is 4 cycles when `resp_ready` is held high.
- `fa_done` in the same cycle as the timeout terminal count: done wins, no kill.
- `resp_ready` already high when `resp_valid` rises: the response completes that same cycle.
- Only one operation is in flight at a time; there is no queuing.
- `rst` asserted in any state:
  - Next cycle returns to IDLE with reset values.
  - An in-flight response is discarded and `fa_kill` is not pulsed. Integration resets the adder alongside this block.

## Structure
- Package `float_sched_pkg` holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - flag constants `FLAG_OK`, `FLAG_OVF`, `FLAG_UNF`, `FLAG_ABN`;
  - `TIMEOUT_Z=32'hFFFF_FFFF`.
- Sub-module `rr_arbiter` is purely combinational: inputs `req`, `ptr`; outputs one-hot `grant` and index `gidx`.
- `float_add_scheduler` owns the FSM, the pointer, the timeout counter and the registers.

## Test plan
- **Single request:** requester 1 with x=32'h3F80_0000 and y=32'h4000_0000; adder model returns `fa_z=32'h4040_0000` with flag 00 after L=5.
  - Expect `fa_start` 1 cycle after accept.
  - Expect `resp_valid=4'b0010` at cycle 7 with z=32'h4040_0000 and flag 00.
- **Contention:** all 4 requesters valid continuously.
  - Grants occur in order 0,1,2,3,0.
  - Each grant sees exactly one `req_ready` pulse.
- **Timeout:** adder model never asserts done; TIMEOUT=64.
  - `fa_kill` pulses once.
  - Response is z=32'hFFFF_FFFF, flag 11.
  - `busy` stays high throughout.
- **Backpressure:** `resp_ready[2]` held low 10 cycles.
  - `resp_valid[2]`, z and flag stay stable.
  - No new `req_ready` is issued to any requester.
  - Accept resumes the cycle after the handshake.
- **Reset mid-WAIT:** `rst` is pulsed 3 cycles after `fa_start`.
  - All outputs return to reset values the next cycle.
  - A later request from requester 3 is granted first (`rr_ptr=0`, only 3 valid).
- **Done/timeout collision:** `fa_done` arrives at the terminal count.
  - Captured `fa_z` is returned.
  - `fa_kill` stays 0.

Source files
------------

// File: rtl/float_sched_pkg.sv
// Shared types and constants for the float adder scheduler.
// State encoding is fixed so the state register can be probed on hardware.
package float_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] FLAG_OK  = 2'b00;
  localparam logic [1:0] FLAG_OVF = 2'b01;
  localparam logic [1:0] FLAG_UNF = 2'b10;
  localparam logic [1:0] FLAG_ABN = 2'b11;

  localparam logic [31:0] TIMEOUT_Z = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] gidx
);

  logic [IW:0] pos;
  logic        found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // One extra bit so the wrap works for non-power-of-two N.
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) begin
        pos = pos - (IW+1)'(N);
      end
      if (!found && req[pos[IW-1:0]]) begin
        found                = 1'b1;
        grant[pos[IW-1:0]]   = 1'b1;
        gidx                 = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/float_add_scheduler.sv
// Time-shares one multi-cycle float adder among N_REQ clients, round-robin,
// one operation in flight, with a done-or-timeout wait and a result handshake.
module float_add_scheduler
  import float_sched_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  output logic [N_REQ-1:0]     req_ready,
  input  logic [32*N_REQ-1:0]  req_x,
  input  logic [32*N_REQ-1:0]  req_y,
  output logic [N_REQ-1:0]     resp_valid,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [31:0]          resp_z,
  output logic [1:0]           resp_flag,
  output logic                 fa_start,
  output logic [31:0]          fa_x,
  output logic [31:0]          fa_y,
  input  logic                 fa_done,
  input  logic [31:0]          fa_z,
  input  logic [1:0]           fa_flag,
  output logic                 fa_kill,
  output logic                 busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);

  state_t           state;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    gidx_reg;
  logic [CW-1:0]    cnt;
  logic [N_REQ-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;
  logic [31:0]      x_arr [N_REQ];
  logic [31:0]      y_arr [N_REQ];
  logic             req_fire;
  logic             resp_fire;
  logic [N_REQ-1:0] g_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign x_arr[gi] = req_x[32*gi +: 32];
      assign y_arr[gi] = req_y[32*gi +: 32];
    end
  endgenerate

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .gidx  (arb_idx)
  );

  // Grant is offered only while idle and never while reset is held.
  assign req_ready = (state == IDLE && !rst) ? arb_grant : '0;
  assign req_fire  = |req_ready;
  assign resp_fire = |(resp_valid & resp_ready);
  assign busy      = (state != IDLE);
  assign g_onehot  = {{(N_REQ-1){1'b0}}, 1'b1} << gidx_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      gidx_reg   <= '0;
      cnt        <= '0;
      fa_start   <= 1'b0;
      fa_kill    <= 1'b0;
      fa_x       <= '0;
      fa_y       <= '0;
      resp_z     <= '0;
      resp_flag  <= '0;
      resp_valid <= '0;
    end else begin
      fa_start <= 1'b0;
      fa_kill  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_fire) begin
            gidx_reg <= arb_idx;
            fa_x     <= x_arr[arb_idx];
            fa_y     <= y_arr[arb_idx];
            fa_start <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A done strobe on the terminal count takes priority over the timeout.
          if (fa_done) begin
            resp_z     <= fa_z;
            resp_flag  <= fa_flag;
            resp_valid <= g_onehot;
            state      <= RESP;
          end else if (cnt == CW'(TIMEOUT-1)) begin
            resp_z     <= TIMEOUT_Z;
            resp_flag  <= FLAG_ABN;
            resp_valid <= g_onehot;
            fa_kill    <= 1'b1;
            state      <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_fire) begin
            resp_valid <= '0;
            rr_ptr     <= (gidx_reg == IW'(N_REQ-1)) ? '0 : gidx_reg + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_float_add_scheduler.sv
// Directed bench for float_add_scheduler with a hand-driven adder model.
module tb_float_add_scheduler;
  import float_sched_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_x;
  logic [127:0] req_y;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [31:0]  resp_z;
  logic [1:0]   resp_flag;
  logic         fa_start;
  logic [31:0]  fa_x;
  logic [31:0]  fa_y;
  logic         fa_done;
  logic [31:0]  fa_z;
  logic [1:0]   fa_flag;
  logic         fa_kill;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  float_add_scheduler #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_z     (resp_z),
    .resp_flag  (resp_flag),
    .fa_start   (fa_start),
    .fa_x       (fa_x),
    .fa_y       (fa_y),
    .fa_done    (fa_done),
    .fa_z       (fa_z),
    .fa_flag    (fa_flag),
    .fa_kill    (fa_kill),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = '0; resp_ready = '0; req_x = '0; req_y = '0;
    fa_done = 1'b0; fa_z = '0; fa_flag = '0;
    step; step;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, fa_start, fa_kill, busy} !== 11'b0)
      $display("FAIL reset_ctrl got=%h want=000", {req_ready, resp_valid, fa_start, fa_kill, busy});
    checks++;
    if ({fa_x, fa_y, resp_z, resp_flag} !== 98'b0)
      $display("FAIL reset_data got=%h want=0", {fa_x, fa_y, resp_z, resp_flag});
    if ({req_ready, resp_valid, fa_start, fa_kill, busy} !== 11'b0) failures++;
    if ({fa_x, fa_y, resp_z, resp_flag} !== 98'b0) failures++;
    $display("test_reset done");
    step;
  endtask

  task automatic test_contention;
    int          exp_seq [5] = '{0, 1, 2, 3, 0};
    int          ngrant = 0;
    int          last_c = 0;
    int          last_idx = 0;
    logic        start_prev = 1'b0;
    logic [3:0]  one;
    for (int i = 0; i < 4; i++) begin
      req_x[32*i +: 32] = 32'h1000_0000 + i;
      req_y[32*i +: 32] = 32'h2000_0000 + i;
    end
    req_valid = 4'hF; resp_ready = 4'hF; fa_z = 32'hA000_0000; fa_flag = FLAG_OK;
    for (int c = 0; c < 60 && ngrant < 5; c++) begin
      fa_done = start_prev;
      @(negedge clk);
      start_prev = fa_start;
      if (fa_start) begin
        checks++;
        if (fa_x !== 32'h1000_0000 + last_idx) begin
          failures++;
          $display("FAIL cont_fa_x got=%h want=%h", fa_x, 32'h1000_0000 + last_idx);
        end
      end
      if (resp_valid != 4'b0) begin
        one = 4'b0001 << last_idx;
        checks++;
        if (resp_valid !== one || resp_z !== 32'hA000_0000) begin
          failures++;
          $display("FAIL cont_resp got=%b/%h want=%b/a0000000", resp_valid, resp_z, one);
        end
      end
      if (req_ready != 4'b0) begin
        one = 4'b0001 << exp_seq[ngrant];
        checks++;
        if (req_ready !== one) begin
          failures++;
          $display("FAIL cont_grant%0d got=%b want=%b", ngrant, req_ready, one);
        end
        if (ngrant > 0) begin
          checks++;
          if (c - last_c != 4) begin
            failures++;
            $display("FAIL cont_interval got=%0d want=4", c - last_c);
          end
        end
        last_c = c; last_idx = exp_seq[ngrant]; ngrant++;
      end
      step;
    end
    checks++;
    if (ngrant != 5) begin
      failures++;
      $display("FAIL cont_count got=%0d want=5", ngrant);
    end
    req_valid = '0;
    for (int c = 0; c < 10; c++) begin
      fa_done = start_prev;
      @(negedge clk);
      start_prev = fa_start;
      if (!busy) break;
      step;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL cont_drain busy got=%b want=0", busy);
    end
    fa_done = 1'b0;
    step;
    $display("test_contention done grants=%0d", ngrant);
  endtask

  task automatic test_single;
    req_valid = 4'b0010; resp_ready = '0;
    req_x[63:32] = 32'h3F80_0000; req_y[63:32] = 32'h4000_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL single_accept got=%b want=0010", req_ready);
    end
    step;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1 || fa_x !== 32'h3F80_0000 || fa_y !== 32'h4000_0000) begin
      failures++; $display("FAIL single_start got=%b/%h/%h want=1/3f800000/40000000", fa_start, fa_x, fa_y);
    end
    step;
    for (int c = 2; c <= 6; c++) begin
      fa_done = (c == 6); fa_z = 32'h4040_0000; fa_flag = FLAG_OK;
      @(negedge clk);
      checks++;
      if (resp_valid !== 4'b0 || fa_start !== 1'b0) begin
        failures++; $display("FAIL single_wait c=%0d got=%b/%b want=0000/0", c, resp_valid, fa_start);
      end
      step;
    end
    fa_done = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0010 || resp_z !== 32'h4040_0000 || resp_flag !== FLAG_OK) begin
      failures++; $display("FAIL single_resp got=%b/%h/%b want=0010/40400000/00", resp_valid, resp_z, resp_flag);
    end
    step;
    resp_ready = 4'b0010;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0010) begin
      failures++; $display("FAIL single_hold got=%b want=0010", resp_valid);
    end
    step;
    resp_ready = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || resp_valid !== 4'b0) begin
      failures++; $display("FAIL single_idle got=%b/%b want=0/0000", busy, resp_valid);
    end
    step;
    $display("test_single done");
  endtask

  task automatic test_timeout;
    int          kills = 0;
    int          kill_cyc = -1;
    int          resp_cyc = -1;
    int          busy_low = 0;
    logic [31:0] z_seen = '0;
    logic [1:0]  f_seen = '0;
    req_valid = 4'b0001; resp_ready = 4'b0001; fa_done = 1'b0;
    req_x[31:0] = 32'h3F80_0000; req_y[31:0] = 32'hBF80_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL to_accept got=%b want=0001", req_ready);
    end
    step;
    req_valid = '0;
    for (int c = 1; c <= 66; c++) begin
      @(negedge clk);
      if (fa_kill) begin kills++; kill_cyc = c; end
      if (!busy) busy_low++;
      if (resp_valid == 4'b0001) begin resp_cyc = c; z_seen = resp_z; f_seen = resp_flag; end
      step;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fa_kill !== 1'b0) begin
      failures++; $display("FAIL to_after got=%b/%b want=0/0", busy, fa_kill);
    end
    step;
    checks++;
    if (kills != 1 || kill_cyc != 66) begin
      failures++; $display("FAIL to_kill got=%0d@%0d want=1@66", kills, kill_cyc);
    end
    checks++;
    if (resp_cyc != 66 || z_seen !== TIMEOUT_Z || f_seen !== FLAG_ABN) begin
      failures++; $display("FAIL to_resp got=%0d/%h/%b want=66/ffffffff/11", resp_cyc, z_seen, f_seen);
    end
    checks++;
    if (busy_low != 0) begin
      failures++; $display("FAIL to_busy low_cycles got=%0d want=0", busy_low);
    end
    resp_ready = '0;
    $display("test_timeout done");
  endtask

  task automatic test_backpressure;
    req_valid = 4'b0100; resp_ready = '0; fa_done = 1'b0;
    req_x[95:64] = 32'h4000_0000; req_y[95:64] = 32'h4100_0000;
    req_x[127:96] = 32'h3F00_0000; req_y[127:96] = 32'h3E00_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL bp_accept got=%b want=0100", req_ready);
    end
    step;
    req_valid = 4'b1011;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1 || fa_x !== 32'h4000_0000 || req_ready !== 4'b0) begin
      failures++; $display("FAIL bp_start got=%b/%h/%b want=1/40000000/0000", fa_start, fa_x, req_ready);
    end
    step;
    fa_done = 1'b1; fa_z = 32'h4110_0000; fa_flag = FLAG_OVF;
    @(negedge clk);
    step;
    fa_done = 1'b0; fa_z = 32'hDEAD_BEEF; fa_flag = FLAG_UNF;
    for (int c = 3; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 4'b0100 || resp_z !== 32'h4110_0000 || resp_flag !== FLAG_OVF || req_ready !== 4'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d got=%b/%h/%b/%b want=0100/41100000/01/0000", c, resp_valid, resp_z, resp_flag, req_ready);
      end
      step;
    end
    resp_ready = 4'b0100;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0100) begin
      failures++; $display("FAIL bp_release got=%b want=0100", resp_valid);
    end
    step;
    resp_ready = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL bp_resume got=%b want=1000", req_ready);
    end
    step;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1 || fa_x !== 32'h3F00_0000 || fa_y !== 32'h3E00_0000) begin
      failures++; $display("FAIL bp_start3 got=%b/%h/%h want=1/3f000000/3e000000", fa_start, fa_x, fa_y);
    end
    step;
    fa_done = 1'b1; fa_z = 32'h4000_0001; fa_flag = FLAG_OK;
    @(negedge clk);
    step;
    fa_done = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b1000 || resp_z !== 32'h4000_0001) begin
      failures++; $display("FAIL bp_resp3 got=%b/%h want=1000/40000001", resp_valid, resp_z);
    end
    step;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL bp_idle got=%b want=0", busy);
    end
    step;
    resp_ready = '0;
    $display("test_backpressure done");
  endtask

  task automatic test_reset_mid_wait;
    req_valid = 4'b0010; resp_ready = '0; fa_done = 1'b0;
    req_x[63:32] = 32'h4040_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL rmw_accept got=%b want=0010", req_ready);
    end
    step;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1) begin
      failures++; $display("FAIL rmw_start got=%b want=1", fa_start);
    end
    step;
    step;
    step;
    rst = 1'b1; fa_done = 1'b1; fa_z = 32'h1234_5678; fa_flag = FLAG_OVF;
    step;
    rst = 1'b0; fa_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, fa_start, fa_kill, busy} !== 11'b0) begin
      failures++; $display("FAIL rmw_ctrl got=%h want=000", {req_ready, resp_valid, fa_start, fa_kill, busy});
    end
    checks++;
    if ({fa_x, fa_y, resp_z, resp_flag} !== 98'b0) begin
      failures++; $display("FAIL rmw_data got=%h want=0", {fa_x, fa_y, resp_z, resp_flag});
    end
    step;
    req_valid = 4'b1000; req_x[127:96] = 32'h4000_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL rmw_grant3 got=%b want=1000", req_ready);
    end
    step;
    req_valid = '0; resp_ready = 4'b1000;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1 || fa_x !== 32'h4000_0000) begin
      failures++; $display("FAIL rmw_start3 got=%b/%h want=1/40000000", fa_start, fa_x);
    end
    step;
    fa_done = 1'b1; fa_z = 32'h4080_0000; fa_flag = FLAG_OK;
    @(negedge clk);
    step;
    fa_done = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b1000 || resp_z !== 32'h4080_0000) begin
      failures++; $display("FAIL rmw_resp3 got=%b/%h want=1000/40800000", resp_valid, resp_z);
    end
    step;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL rmw_idle got=%b want=0", busy);
    end
    step;
    resp_ready = '0;
    $display("test_reset_mid_wait done");
  endtask

  task automatic test_collision;
    int early = 0;
    req_valid = 4'b0001; resp_ready = 4'b0001; fa_done = 1'b0;
    req_x[31:0] = 32'h4100_0000; req_y[31:0] = 32'h4110_0000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL col_accept got=%b want=0001", req_ready);
    end
    step;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (fa_start !== 1'b1) begin
      failures++; $display("FAIL col_start got=%b want=1", fa_start);
    end
    step;
    for (int c = 2; c <= 65; c++) begin
      fa_done = (c == 65); fa_z = 32'h4188_0000; fa_flag = FLAG_UNF;
      @(negedge clk);
      if (fa_kill || resp_valid != 4'b0 || !busy) early++;
      step;
    end
    fa_done = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 4'b0001 || resp_z !== 32'h4188_0000 || resp_flag !== FLAG_UNF || fa_kill !== 1'b0) begin
      failures++;
      $display("FAIL col_resp got=%b/%h/%b/%b want=0001/41880000/10/0", resp_valid, resp_z, resp_flag, fa_kill);
    end
    step;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || fa_kill !== 1'b0) begin
      failures++; $display("FAIL col_idle got=%b/%b want=0/0", busy, fa_kill);
    end
    step;
    checks++;
    if (early != 0) begin
      failures++; $display("FAIL col_wait early_events got=%0d want=0", early);
    end
    resp_ready = '0;
    $display("test_collision done");
  endtask

  initial begin
    test_reset;
    test_contention;
    test_single;
    test_timeout;
    test_backpressure;
    test_reset_mid_wait;
    test_collision;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
